// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a value; unsigned operands pass through untouched.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply (shift-add) or restoring divide (shift-subtract).
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] operand,
    output logic [31:0] nxt_hi,
    output logic [31:0] nxt_lo
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;

    always_comb begin
        // NOTE: every output is assigned a default first so no path can infer a latch.
        nxt_hi  = acc_hi;
        nxt_lo  = acc_lo;
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
        shifted = {acc_hi, acc_lo[31]};
        fits    = shifted >= {1'b0, operand};
        // When the subtraction fits, the partial remainder is below the divisor,
        // so the low 32 bits of the difference are exact.
        diff    = shifted[31:0] - operand;

        if (is_div) begin
            nxt_hi = fits ? diff : shifted[31:0];
            nxt_lo = {acc_lo[30:0], fits};
        end else begin
            nxt_hi = sum[32:1];
            nxt_lo = {sum[0], acc_lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// HI/LO owner and sequencer for iterative mult/multu/div/divu.
// Optional: MULDIV_FAST_MUL_EN computes multiplies in one step and skips RUN.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_hi,
    input  logic        rd_lo,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       acc_hi;
    logic [31:0]       acc_lo;
    logic [31:0]       operand;
    logic [31:0]       dividend_raw;
    logic              is_div;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;

    logic              signed_op;
    logic              op_div;
    logic [31:0]       mag_a;
    logic [31:0]       mag_b;
    logic [31:0]       step_hi;
    logic [31:0]       step_lo;
    logic [63:0]       prod_fix;
    logic [31:0]       quo_fix;
    logic [31:0]       rem_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = op[1];
    assign mag_a     = abs32(rs_val, signed_op);
    assign mag_b     = abs32(rt_val, signed_op);

    // Requests are held upstream while an operation owns HI/LO.
    assign stall = busy && (start | rd_hi | rd_lo | mthi | mtlo);

    assign prod_fix = neg_res ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    assign quo_fix  = neg_res ? (~acc_lo + 32'd1) : acc_lo;
    assign rem_fix  = neg_rem ? (~acc_hi + 32'd1) : acc_hi;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, mag_a} * {32'd0, mag_b};
`endif

    muldiv_step u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            operand      <= '0;
            dividend_raw <= '0;
            is_div       <= 1'b0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        cnt          <= {CNT_W{1'b1}};
                        busy         <= 1'b1;
                        is_div       <= op_div;
                        neg_res      <= signed_op && (rs_val[31] ^ rt_val[31]);
                        neg_rem      <= signed_op && rs_val[31];
                        div_zero     <= op_div && (rt_val == 32'd0);
                        dividend_raw <= rs_val;
                        acc_hi       <= '0;
                        // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
                        acc_lo       <= op_div ? mag_a : mag_b;
                        operand      <= op_div ? mag_b : mag_a;
                        state        <= S_RUN;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op_div) begin
                            {acc_hi, acc_lo} <= fast_prod;
                            state            <= S_FIX;
                        end
`endif
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end

                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        if (cnt == '0) state <= S_FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end

                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        if (div_zero) begin
                            hi <= dividend_raw;
                            lo <= DIV0_LO;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized self-checking bench for muldiv_sched against a cycle-count/arithmetic model.
module tb_muldiv_sched;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int MUL_LAT = FAST ? 2 : 34;
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo, rd_hi, rd_lo, flush;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_sched #(.CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .flush(flush),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Model: busy cycles left, architectural HI/LO, pending result.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] p_res = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            chk_en = 1'b1;
        end else if (m_left > 0) begin
            if (flush) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) {m_hi, m_lo} = p_res;
            end
        end else if (start && !flush) begin
            p_res  = ref_result(op, rs_val, rt_val);
            m_left = (!op[1] ? MUL_LAT : DIV_LAT) - 1;
        end else begin
            if (mthi) m_hi = wdata;
            if (mtlo) m_lo = wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  64'(busy),  64'(m_left > 0));
            check("hi",    64'(hi),    64'(m_hi));
            check("lo",    64'(lo),    64'(m_lo));
            check("stall", 64'(stall), 64'((m_left > 0) && (start | rd_hi | rd_lo | mthi | mtlo)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 0; mthi = 0; mtlo = 0; rd_hi = 0; rd_lo = 0; flush = 0;
        op = '0; rs_val = '0; rt_val = '0; wdata = '0;
        tick(); tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        rst = 1'b0;

        check("model_multu", ref_result(OP_MULTU, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);
        check("model_mult",  ref_result(OP_MULT, -32'sd3, 32'd5),        64'hFFFF_FFFF_FFFF_FFF1);
        check("model_div",   ref_result(OP_DIV, -32'sd7, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
        check("model_div0",  ref_result(OP_DIVU, 32'd7, 32'd0),          64'h0000_0007_FFFF_FFFF);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_busy_first", 64'(busy), 64'd1);
        repeat (MUL_LAT - 2) tick();
        check("multu_busy_last", 64'(busy), 64'd1);
        tick();
        check("multu_busy_done", 64'(busy), 64'd0);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        issue(OP_MULT, -32'sd3, 32'd5);
        repeat (MUL_LAT - 1) tick();
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFF1);

        issue(OP_DIV, -32'sd7, 32'd2);
        repeat (DIV_LAT - 1) tick();
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);

        issue(OP_DIVU, 32'd7, 32'd0);
        repeat (DIV_LAT - 1) tick();
        check("div0_hi", 64'(hi), 64'h7);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);

        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) tick();
        rd_lo = 1'b1;
        #1;
        check("rdlo_stall_c5", 64'(stall), 64'd1);
        repeat (28) tick();
        check("rdlo_stall_c33", 64'(stall), 64'd1);
        tick();
        check("rdlo_stall_c34", 64'(stall), 64'd0);
        check("rdlo_lo_c34", 64'(lo), 64'd14);
        rd_lo = 1'b0;

        mthi = 1'b1; wdata = 32'hA5A5_A5A5;
        tick();
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi",   64'(hi),   64'hA5A5_A5A5);
        check("flush_lo",   64'(lo),   64'd14);

        start = 1'b1; flush = 1'b1; op = OP_DIVU;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_blocks_start", 64'(busy), 64'd0);

        issue(OP_DIVU, 32'd50, 32'd5);
        op = OP_DIVU; rs_val = 32'd9; rt_val = 32'd4; start = 1'b1;
        repeat (DIV_LAT - 1) tick();
        check("b2b_idle_c34", 64'(busy), 64'd0);
        check("b2b_first_lo", 64'(lo),   64'd10);
        tick();
        start = 1'b0;
        check("b2b_accept", 64'(busy), 64'd1);
        repeat (DIV_LAT - 1) tick();
        check("b2b_second_lo", 64'(lo), 64'd2);
        check("b2b_second_hi", 64'(hi), 64'd1);

        issue(OP_DIV, 32'd12345, 32'd67);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_hi",   64'(hi),   64'd0);
        check("rst_run_lo",   64'(lo),   64'd0);

        repeat (3000) begin
            int r;
            r      = $urandom_range(0, 15);
            start  = (r < 2);
            mthi   = (r == 2);
            mtlo   = (r == 3);
            flush  = ($urandom_range(0, 63) == 0) && !mthi && !mtlo;
            rd_hi  = ($urandom_range(0, 3) == 0);
            rd_lo  = ($urandom_range(0, 3) == 0);
            op     = 2'($urandom_range(0, 3));
            rs_val = pick();
            rt_val = pick();
            wdata  = $urandom;
            tick();
        end
        start = 0; mthi = 0; mtlo = 0; flush = 0; rd_hi = 0; rd_lo = 0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
